// File: rtl/genaxis_lfsr_desc_gen_if.sv
// Descriptor and payload bus between the LFSR descriptor source (master)
// and the packet FSM / data path (slave).
interface genaxis_lfsr_desc_gen_if #(
   parameter int ID_WIDTH   = 10,
   parameter int DATA_WIDTH = 32
);
   // desc_valid rises only when a descriptor is held; once high it, and
   // every pkt_* field, stay stable until the cycle desc_valid & desc_ready
   // are both high at a clock edge. desc_valid never depends on desc_ready.
   logic                  desc_valid;
   logic                  desc_ready;
   logic [15:0]           pkt_length;
   logic [ID_WIDTH-1:0]   pkt_channel;
   logic [31:0]           pkt_pause;
   logic                  data_req;
   logic [DATA_WIDTH-1:0] pkt_data;

   modport master (
      output desc_valid, pkt_length, pkt_channel, pkt_pause, pkt_data,
      input  desc_ready, data_req
   );

   modport slave (
      input  desc_valid, pkt_length, pkt_channel, pkt_pause, pkt_data,
      output desc_ready, data_req
   );
endinterface

// File: rtl/genaxis_lfsr_desc_gen.sv
// Pseudo-random descriptor/payload source: two Galois LFSRs feeding a 2-stage
// capture -> range-map pipeline and a registered payload word.
module genaxis_lfsr_desc_gen #(
   parameter int                ID_WIDTH   = 10,
   parameter int                DATA_WIDTH = 32,
   parameter int                LFSR_W     = 64,
   parameter logic [LFSR_W-1:0] TAPS       = 64'hD800000000000000,
   parameter logic [LFSR_W-1:0] SEED_D     = 64'h1,
   parameter logic [LFSR_W-1:0] SEED_P     = 64'hACE1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                seed_load_i,
   input  logic [LFSR_W-1:0]   seed_d_i,
   input  logic [LFSR_W-1:0]   seed_p_i,
   input  logic [15:0]         cntrl_min_length_i,
   input  logic [15:0]         cntrl_max_length_i,
   input  logic [ID_WIDTH-1:0] cntrl_min_channel_i,
   input  logic [ID_WIDTH-1:0] cntrl_max_channel_i,
   input  logic [31:0]         cntrl_min_pause_i,
   input  logic [31:0]         cntrl_max_pause_i,
   genaxis_lfsr_desc_gen_if.master desc_if,
   output logic                cfg_err_o
);

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : '0);
   endfunction

   logic [LFSR_W-1:0]     r_lfsr_d, r_lfsr_p;
   logic [LFSR_W-1:0]     w_seed_d, w_seed_p, w_lfsr_d_nxt, w_lfsr_p_nxt;
   logic                  r_s1_vld, r_s2_vld;
   logic                  w_s2_load, w_s1_move, w_s1_cap;

   logic [15:0]           r_s1_len_raw, r_s1_len_min;
   logic [16:0]           r_s1_len_span;
   logic [ID_WIDTH-1:0]   r_s1_ch_raw, r_s1_ch_min;
   logic [ID_WIDTH:0]     r_s1_ch_span;
   logic [31:0]           r_s1_pse_raw, r_s1_pse_min;
   logic [32:0]           r_s1_pse_span;

   logic                  w_len_bad, w_ch_bad, w_pse_bad;
   logic [16:0]           w_len_span;
   logic [ID_WIDTH:0]     w_ch_span;
   logic [32:0]           w_pse_span;

   logic [32:0]           w_len_prod;
   logic [2*ID_WIDTH:0]   w_ch_prod;
   logic [64:0]           w_pse_prod;
   logic [15:0]           w_len_map;
   logic [ID_WIDTH-1:0]   w_ch_map;
   logic [31:0]           w_pse_map;

   logic [15:0]           r_len;
   logic [ID_WIDTH-1:0]   r_ch;
   logic [31:0]           r_pse;
   logic [DATA_WIDTH-1:0] r_data, w_data_mix;
   logic                  r_cfg_err;

   assign w_seed_d = (seed_d_i == '0) ? SEED_D : seed_d_i;
   assign w_seed_p = (seed_p_i == '0) ? SEED_P : seed_p_i;

   assign w_s2_load = !r_s2_vld || desc_if.desc_ready;
   assign w_s1_move = r_s1_vld && w_s2_load;
   assign w_s1_cap  = !r_s1_vld || w_s1_move;

   assign w_lfsr_d_nxt = seed_load_i ? w_seed_d :
                         (w_s1_cap ? lfsr_step(r_lfsr_d) : r_lfsr_d);
   assign w_lfsr_p_nxt = seed_load_i ? w_seed_p :
                         (desc_if.data_req ? lfsr_step(r_lfsr_p) : r_lfsr_p);

   // A bad range collapses to span 1, so the map below yields exactly min.
   assign w_len_bad  = cntrl_min_length_i  > cntrl_max_length_i;
   assign w_ch_bad   = cntrl_min_channel_i > cntrl_max_channel_i;
   assign w_pse_bad  = cntrl_min_pause_i   > cntrl_max_pause_i;
   assign w_len_span = w_len_bad ? 17'd1 :
                       ({1'b0, cntrl_max_length_i} - {1'b0, cntrl_min_length_i} + 17'd1);
   assign w_ch_span  = w_ch_bad ? {{ID_WIDTH{1'b0}}, 1'b1} :
                       ({1'b0, cntrl_max_channel_i} - {1'b0, cntrl_min_channel_i}
                        + {{ID_WIDTH{1'b0}}, 1'b1});
   assign w_pse_span = w_pse_bad ? 33'd1 :
                       ({1'b0, cntrl_max_pause_i} - {1'b0, cntrl_min_pause_i} + 33'd1);

   // raw < 2^W and span <= 2^W, so the product's top bit is always zero and
   // the shifted result is strictly below span: min + result never overflows.
   assign w_len_prod = {17'b0, r_s1_len_raw} * {16'b0, r_s1_len_span};
   assign w_ch_prod  = {{(ID_WIDTH+1){1'b0}}, r_s1_ch_raw} * {{ID_WIDTH{1'b0}}, r_s1_ch_span};
   assign w_pse_prod = {33'b0, r_s1_pse_raw} * {32'b0, r_s1_pse_span};
   assign w_len_map  = r_s1_len_min + w_len_prod[31:16];
   assign w_ch_map   = r_s1_ch_min + w_ch_prod[2*ID_WIDTH-1:ID_WIDTH];
   assign w_pse_map  = r_s1_pse_min + w_pse_prod[63:32];

   always_comb begin
      w_data_mix = '0;
      for (int i = 0; i < DATA_WIDTH; i++)
         w_data_mix[i] = w_lfsr_p_nxt[i] ^ r_lfsr_d[(i + LFSR_W/2) % LFSR_W];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lfsr_d <= SEED_D;
         r_lfsr_p <= SEED_P;
      end else begin
         r_lfsr_d <= w_lfsr_d_nxt;
         r_lfsr_p <= w_lfsr_p_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_vld      <= 1'b0;
         r_s1_len_raw  <= '0;
         r_s1_len_min  <= '0;
         r_s1_len_span <= '0;
         r_s1_ch_raw   <= '0;
         r_s1_ch_min   <= '0;
         r_s1_ch_span  <= '0;
         r_s1_pse_raw  <= '0;
         r_s1_pse_min  <= '0;
         r_s1_pse_span <= '0;
      end else if (seed_load_i) begin
         r_s1_vld <= 1'b0;
      end else if (w_s1_cap) begin
         r_s1_vld      <= 1'b1;
         r_s1_len_raw  <= r_lfsr_d[15:0];
         r_s1_len_min  <= cntrl_min_length_i;
         r_s1_len_span <= w_len_span;
         r_s1_ch_raw   <= r_lfsr_d[16 +: ID_WIDTH];
         r_s1_ch_min   <= cntrl_min_channel_i;
         r_s1_ch_span  <= w_ch_span;
         r_s1_pse_raw  <= r_lfsr_d[LFSR_W-1 -: 32];
         r_s1_pse_min  <= cntrl_min_pause_i;
         r_s1_pse_span <= w_pse_span;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s2_vld <= 1'b0;
         r_len    <= '0;
         r_ch     <= '0;
         r_pse    <= '0;
      end else if (seed_load_i) begin
         r_s2_vld <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_len <= w_len_map;
            r_ch  <= w_ch_map;
            r_pse <= w_pse_map;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data    <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         if (desc_if.data_req)
            r_data <= w_data_mix;
         r_cfg_err <= r_cfg_err || w_len_bad || w_ch_bad || w_pse_bad;
      end
   end

   assign desc_if.desc_valid  = r_s2_vld;
   assign desc_if.pkt_length  = r_len;
   assign desc_if.pkt_channel = r_ch;
   assign desc_if.pkt_pause   = r_pse;
   assign desc_if.pkt_data    = r_data;
   assign cfg_err_o           = r_cfg_err;

endmodule

// File: tb/tb_genaxis_lfsr_desc_gen.sv
// Directed bench for genaxis_lfsr_desc_gen: reset, ranged/full-range descriptors,
// config error, seed reload, payload stepping.
module tb_genaxis_lfsr_desc_gen;

   localparam logic [63:0] TAPS   = 64'hD800000000000000;
   localparam logic [63:0] SEED_D = 64'h1;
   localparam logic [63:0] SEED_P = 64'hACE1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        seed_load_i = 1'b0;
   logic [63:0] seed_d_i = '0, seed_p_i = '0;
   logic [15:0] min_len = 16'd64, max_len = 16'd64;
   logic [9:0]  min_ch = 10'd3, max_ch = 10'd3;
   logic [31:0] min_pse = 32'd0, max_pse = 32'd0;
   logic        cfg_err_o;

   int          n_pass = 0;
   int          n_total = 0;
   logic [63:0] model_d;

   genaxis_lfsr_desc_gen_if #(.ID_WIDTH(10), .DATA_WIDTH(32)) dif ();

   genaxis_lfsr_desc_gen dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .seed_load_i         (seed_load_i),
      .seed_d_i            (seed_d_i),
      .seed_p_i            (seed_p_i),
      .cntrl_min_length_i  (min_len),
      .cntrl_max_length_i  (max_len),
      .cntrl_min_channel_i (min_ch),
      .cntrl_max_channel_i (max_ch),
      .cntrl_min_pause_i   (min_pse),
      .cntrl_max_pause_i   (max_pse),
      .desc_if             (dif.master),
      .cfg_err_o           (cfg_err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] step(input logic [63:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : 64'd0);
   endfunction

   function automatic longint unsigned map_f(input longint unsigned raw, mn, mx, input int w);
      longint unsigned span;
      if (mn > mx) return mn;
      span = mx - mn + 1;
      return mn + ((raw * span) >> w);
   endfunction

   function automatic logic [31:0] mix(input logic [63:0] p, d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = p[i] ^ d[(i + 32) % 64];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic seed_load(input logic [63:0] sd, input logic [63:0] sp);
      seed_d_i    = sd;
      seed_p_i    = sp;
      seed_load_i = 1'b1;
      tick();
      seed_load_i = 1'b0;
      model_d     = (sd == 64'd0) ? SEED_D : sd;
   endtask

   // Accept n descriptors, each compared with the model; stalls must hold fields.
   task automatic run_descs(input int n, input bit rnd);
      int          got = 0;
      int          guard = 0;
      bit          stalled;
      logic [15:0] s_len;
      logic [9:0]  s_ch;
      logic [31:0] s_pse;
      while (got < n && guard < n * 20 + 20) begin
         dif.desc_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         stalled = 1'b0;
         if (dif.desc_valid && dif.desc_ready) begin
            check("len", {48'd0, dif.pkt_length},
                  map_f(longint'(model_d[15:0]), longint'(min_len), longint'(max_len), 16));
            check("ch", {54'd0, dif.pkt_channel},
                  map_f(longint'(model_d[25:16]), longint'(min_ch), longint'(max_ch), 10));
            check("pause", {32'd0, dif.pkt_pause},
                  map_f(longint'(model_d[63:32]), longint'(min_pse), longint'(max_pse), 32));
            model_d = step(model_d);
            got++;
         end else if (dif.desc_valid) begin
            stalled = 1'b1;
            s_len = dif.pkt_length;
            s_ch  = dif.pkt_channel;
            s_pse = dif.pkt_pause;
         end
         tick();
         if (stalled) begin
            check("stall_valid", {63'd0, dif.desc_valid}, 64'd1);
            check("stall_fields", {dif.pkt_length, dif.pkt_channel, dif.pkt_pause},
                  {s_len, s_ch, s_pse});
         end
         guard++;
      end
      check("desc_timeout", 64'(got), 64'(n));
   endtask

   initial begin
      logic [63:0] p, d;
      logic [31:0] hold;
      int          waited;
      dif.desc_ready = 1'b1;
      dif.data_req   = 1'b0;
      model_d        = SEED_D;

      // T1: reset values, 2-cycle latency, degenerate ranges
      tick();
      tick();
      check("rst_valid", {63'd0, dif.desc_valid}, 64'd0);
      check("rst_len", {48'd0, dif.pkt_length}, 64'd0);
      check("rst_ch", {54'd0, dif.pkt_channel}, 64'd0);
      check("rst_pause", {32'd0, dif.pkt_pause}, 64'd0);
      check("rst_cfg_err", {63'd0, cfg_err_o}, 64'd0);
      reset_n = 1'b1;
      tick();
      check("lat_c1_valid", {63'd0, dif.desc_valid}, 64'd0);
      tick();
      check("lat_c2_valid", {63'd0, dif.desc_valid}, 64'd1);
      check("t1_len", {48'd0, dif.pkt_length}, 64'd64);
      check("t1_ch", {54'd0, dif.pkt_channel}, 64'd3);
      check("t1_pause", {32'd0, dif.pkt_pause}, 64'd0);
      run_descs(8, 1'b0);
      check("t1_len_late", {48'd0, dif.pkt_length}, 64'd64);
      check("t1_cfg_err", {63'd0, cfg_err_o}, 64'd0);

      // T2: typical ranges, random backpressure
      min_len = 16'd60;  max_len = 16'd1500;
      min_ch  = 10'd0;   max_ch  = 10'd7;
      min_pse = 32'd10;  max_pse = 32'd20;
      seed_load(64'd0, 64'd0);
      check("t2_flush_valid", {63'd0, dif.desc_valid}, 64'd0);
      run_descs(200, 1'b1);

      // T3: full range passes raw LFSR fields straight through
      dif.desc_ready = 1'b1;
      min_len = 16'd0;  max_len = 16'hFFFF;
      min_ch  = 10'd0;  max_ch  = 10'h3FF;
      min_pse = 32'd0;  max_pse = 32'hFFFF_FFFF;
      seed_load(64'h0123_4567_89AB_CDEF, 64'd0);
      waited = 0;
      while (!dif.desc_valid && waited < 4) begin tick(); waited++; end
      check("t3_raw", {dif.pkt_length, dif.pkt_channel, dif.pkt_pause},
            {16'hCDEF, 10'h1AB, 32'h0123_4567});
      run_descs(40, 1'b0);

      // T4: inverted length range clamps to min, error sticky
      min_len = 16'd20; max_len = 16'd10;
      min_ch  = 10'd2;  max_ch  = 10'd5;
      min_pse = 32'd1;  max_pse = 32'd100;
      tick();
      check("t4_cfg_err_set", {63'd0, cfg_err_o}, 64'd1);
      seed_load(64'd0, 64'd0);
      run_descs(10, 1'b0);
      check("t4_len_min", {48'd0, dif.pkt_length}, 64'd20);
      min_len = 16'd60; max_len = 16'd1500;
      tick();
      tick();
      check("t4_cfg_err_sticky", {63'd0, cfg_err_o}, 64'd1);

      // Reset mid-operation takes effect asynchronously
      #2 reset_n = 1'b0;
      #1;
      check("arst_valid", {63'd0, dif.desc_valid}, 64'd0);
      check("arst_len", {48'd0, dif.pkt_length}, 64'd0);
      check("arst_cfg_err", {63'd0, cfg_err_o}, 64'd0);
      tick();
      reset_n = 1'b1;
      model_d = SEED_D;

      // T5: zero-seed reload mid-stream restarts the post-reset sequence
      min_len = 16'd60;  max_len = 16'd1500;
      min_ch  = 10'd0;   max_ch  = 10'd7;
      min_pse = 32'd10;  max_pse = 32'd20;
      run_descs(5, 1'b0);
      seed_load(64'd0, 64'd0);
      check("t5_valid_drop", {63'd0, dif.desc_valid}, 64'd0);
      run_descs(12, 1'b0);

      // T6: payload words advance only on data_req
      dif.desc_ready = 1'b0;
      seed_load(64'hDEAD_BEEF_0000_1234, 64'd0);
      repeat (4) tick();
      d = step(step(64'hDEAD_BEEF_0000_1234));
      p = SEED_P;
      for (int k = 0; k < 3; k++) begin
         dif.data_req = 1'b1;
         tick();
         dif.data_req = 1'b0;
         p = step(p);
         check("t6_data", {32'd0, dif.pkt_data}, {32'd0, mix(p, d)});
         hold = mix(p, d);
         repeat (2) begin
            tick();
            check("t6_hold", {32'd0, dif.pkt_data}, {32'd0, hold});
         end
      end
      repeat (4) begin
         tick();
         check("t6_idle", {32'd0, dif.pkt_data}, {32'd0, hold});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
